// File: rtl/m_prog_loader_pkg.sv
// Shared definitions for the UART program loader: state types, frame constants
// and the image-size helper.
package m_prog_loader_pkg;

    localparam int unsigned HDR_W          = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    typedef enum logic [1:0] {
        L_CNT0,
        L_CNT1,
        L_WORD,
        L_DONE
    } ld_state_t;

    // Largest legal word count for a given word-address width.
    function automatic logic [31:0] max_words(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/m_prog_loader_if.sv
// Instruction-memory write port driven by the program loader.
interface m_prog_loader_if #(
    parameter int unsigned ADDR_W = 11
) ();
    logic [ADDR_W-1:0] w_waddr;
    logic [31:0]       w_wdata;
    logic              w_we;

    modport master (output w_waddr, output w_wdata, output w_we);
    modport slave  (input  w_waddr, input  w_wdata, input  w_we);
endinterface

// File: rtl/m_prog_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, one-cycle byte
// strobe on a good stop bit and a one-cycle framing-error strobe otherwise.
module m_uart_rx
    import m_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic       w_clk,
    input  logic       w_rst,
    input  logic       w_rxd,
    output logic [7:0] r_byte,
    output logic       r_valid,
    output logic       r_ferr
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1, sync2;
    rx_state_t        st, st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             at_half, at_full;

    // Bring the asynchronous line into the clock domain (idle high).
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= w_rxd;
            sync2 <= sync1;
        end
    end

    // RX state register.
    always_ff @(posedge w_clk) begin
        if (w_rst) st <= RX_IDLE;
        else       st <= st_nxt;
    end

    // RX next-state logic.
    always_comb begin
        st_nxt  = st;
        at_half = (cnt == HALF_M1);
        at_full = (cnt == FULL_M1);
        unique case (st)
            RX_IDLE:  if (!sync2) st_nxt = RX_START;
            RX_START: if (at_half) st_nxt = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (at_full && bit_idx == 3'd7) st_nxt = RX_STOP;
            RX_STOP:  if (at_full) st_nxt = sync2 ? RX_IDLE : RX_WAIT;
            RX_WAIT:  if (sync2) st_nxt = RX_IDLE;
            default:  st_nxt = RX_IDLE;
        endcase
    end

    // Bit timer, data shift register and output strobes.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (st_nxt != st || (st == RX_DATA && at_full)) cnt <= '0;
            else                                            cnt <= cnt + 1'b1;
            if (st == RX_START) bit_idx <= '0;
            if (st == RX_DATA && at_full) begin
                shreg   <= {sync2, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (st == RX_STOP && at_full) begin
                if (sync2) begin
                    r_byte  <= shreg;
                    r_valid <= 1'b1;
                end else begin
                    r_ferr  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/m_prog_loader.sv
// UART program loader: 16-bit word count header followed by little-endian
// 32-bit words written to instruction memory; holds the processor in reset
// (w_busy) while an image is being loaded.
module m_prog_loader
    import m_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned ADDR_W       = 11
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_rxd,
    m_prog_loader_if.master  imem,
    output logic             w_busy,
    output logic             w_done,
    output logic             w_err
);
    logic [7:0]        rx_byte;
    logic              rx_valid, rx_ferr;

    ld_state_t         st, st_nxt;
    logic [7:0]        n_lo;
    logic [HDR_W-1:0]  n_cnt;
    logic [HDR_W-1:0]  hdr_n;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        k;
    logic [23:0]       wbuf;
    logic              hdr_zero, hdr_big, word_last;

    m_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .w_clk  (w_clk),
        .w_rst  (w_rst),
        .w_rxd  (w_rxd),
        .r_byte (rx_byte),
        .r_valid(rx_valid),
        .r_ferr (rx_ferr)
    );

    // Loader state register.
    always_ff @(posedge w_clk) begin
        if (w_rst) st <= L_CNT0;
        else       st <= st_nxt;
    end

    // Loader next-state logic and header/word decode.
    always_comb begin
        st_nxt    = st;
        hdr_n     = {rx_byte, n_lo};
        hdr_zero  = (hdr_n == '0);
        hdr_big   = (32'(hdr_n) > max_words(ADDR_W));
        word_last = ((32'(addr) + 32'd1) == 32'(n_cnt));
        if (rx_valid) begin
            unique case (st)
                L_CNT0: st_nxt = L_CNT1;
                L_CNT1: begin
                    if (hdr_zero)     st_nxt = L_DONE;
                    else if (hdr_big) st_nxt = L_CNT0;
                    else              st_nxt = L_WORD;
                end
                L_WORD:  if (k == 2'd3 && word_last) st_nxt = L_DONE;
                L_DONE:  st_nxt = L_CNT1;
                default: st_nxt = L_CNT0;
            endcase
        end
    end

    // Header capture, word assembly, address counter and registered outputs.
    // Write address/data are loaded only together with w_we, so they hold
    // between writes while the next word is assembled in wbuf.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            n_lo         <= '0;
            n_cnt        <= '0;
            addr         <= '0;
            k            <= '0;
            wbuf         <= '0;
            imem.w_we    <= 1'b0;
            imem.w_waddr <= '0;
            imem.w_wdata <= '0;
            w_busy       <= 1'b0;
            w_done       <= 1'b0;
            w_err        <= 1'b0;
        end else begin
            imem.w_we <= 1'b0;
            if (rx_ferr) w_err <= 1'b1;
            if (rx_valid) begin
                unique case (st)
                    L_CNT0, L_DONE: begin
                        n_lo   <= rx_byte;
                        w_busy <= 1'b1;
                        w_done <= 1'b0;
                    end
                    L_CNT1: begin
                        n_cnt <= hdr_n;
                        addr  <= '0;
                        k     <= '0;
                        if (hdr_zero) begin
                            w_busy <= 1'b0;
                            w_done <= 1'b1;
                        end else if (hdr_big) begin
                            w_err <= 1'b1;
                        end
                    end
                    L_WORD: begin
                        if (k == 2'd3) begin
                            imem.w_we    <= 1'b1;
                            imem.w_waddr <= addr;
                            imem.w_wdata <= {rx_byte, wbuf};
                            addr         <= addr + 1'b1;
                            k            <= '0;
                            if (word_last) begin
                                w_busy <= 1'b0;
                                w_done <= 1'b1;
                            end
                        end else begin
                            unique case (k)
                                2'd0:    wbuf[7:0]   <= rx_byte;
                                2'd1:    wbuf[15:8]  <= rx_byte;
                                default: wbuf[23:16] <= rx_byte;
                            endcase
                            k <= k + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_m_prog_loader.sv
// Self-checking bench for m_prog_loader: byte-level UART driver, frame-level
// reference model feeding a write scoreboard, and a monitor on the imem port.
module tb_m_prog_loader;
    localparam int unsigned CPB = 4;
    localparam int unsigned AW  = 11;

    logic w_clk = 1'b0;
    logic w_rst = 1'b1;
    logic w_rxd = 1'b1;
    logic w_busy, w_done, w_err;

    m_prog_loader_if #(.ADDR_W(AW)) imem ();

    m_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .w_rxd (w_rxd),
        .imem  (imem.master),
        .w_busy(w_busy),
        .w_done(w_done),
        .w_err (w_err)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    int   errors = 0;
    int   checks = 0;
    wr_t  exp_q[$];

    // Reference model state: image loading described as a byte stream.
    logic [7:0]  m_hdr[$];
    logic [7:0]  m_word[$];
    int unsigned m_left = 0;
    int unsigned m_addr = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hdr.delete();
        m_word.delete();
        m_left = 0;
        m_addr = 0;
        m_busy = 1'b0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int unsigned n;
        wr_t w;
        if (m_left == 0) begin
            if (m_hdr.size() == 0) begin
                m_busy = 1'b1;
                m_done = 1'b0;
            end
            m_hdr.push_back(b);
            if (m_hdr.size() == 2) begin
                n = {16'd0, m_hdr[1], m_hdr[0]};
                m_hdr.delete();
                if (n == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else if (n > (32'd1 << AW)) begin
                    m_err = 1'b1;
                end else begin
                    m_left = n;
                    m_addr = 0;
                    m_word.delete();
                end
            end
        end else begin
            m_word.push_back(b);
            if (m_word.size() == 4) begin
                w.addr = m_addr;
                w.data = {m_word[3], m_word[2], m_word[1], m_word[0]};
                exp_q.push_back(w);
                m_word.delete();
                m_addr++;
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
    endtask

    task automatic send_raw(input logic [7:0] b, input logic stop_ok);
        @(negedge w_clk);
        w_rxd = 1'b0;
        repeat (CPB) @(negedge w_clk);
        for (int i = 0; i < 8; i++) begin
            w_rxd = b[i];
            repeat (CPB) @(negedge w_clk);
        end
        w_rxd = stop_ok;
        repeat (CPB) @(negedge w_clk);
        w_rxd = 1'b1;
        if (!stop_ok) repeat (2 * CPB) @(negedge w_clk);
        repeat ($urandom_range(0, CPB)) @(negedge w_clk);
    endtask

    // Expectations are pushed before the byte goes on the wire.
    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        send_raw(b, 1'b1);
    endtask

    task automatic send_bad_stop(input logic [7:0] b);
        m_err = 1'b1;
        send_raw(b, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] d);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic status(input string tag);
        repeat (8 * CPB) @(negedge w_clk);
        chk({tag, "_busy"}, 32'(w_busy), 32'(m_busy));
        chk({tag, "_done"}, 32'(w_done), 32'(m_done));
        chk({tag, "_err"},  32'(w_err),  32'(m_err));
        chk({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    // Monitor: every write strobe is matched against the scoreboard head.
    always @(negedge w_clk) begin
        if (!w_rst && imem.w_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                         imem.w_waddr, imem.w_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("waddr", 32'(imem.w_waddr), e.addr);
                chk("wdata", imem.w_wdata, e.data);
            end
        end
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int unsigned n;

        repeat (4) @(negedge w_clk);
        chk("rst_waddr", 32'(imem.w_waddr), 0);
        chk("rst_wdata", imem.w_wdata, 0);
        chk("rst_we",    32'(imem.w_we), 0);
        chk("rst_busy",  32'(w_busy), 0);
        chk("rst_done",  32'(w_done), 0);
        chk("rst_err",   32'(w_err), 0);
        w_rst = 1'b0;
        repeat (4) @(negedge w_clk);

        // Two-word image.
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h0000_0020);
        send_word(32'h1122_3344);
        status("t1");

        // Empty image.
        send_byte(8'h00); send_byte(8'h00);
        status("t2");

        // Single-cycle glitch while idle.
        @(negedge w_clk) w_rxd = 1'b0;
        @(negedge w_clk) w_rxd = 1'b1;
        status("t5");

        // Oversized count, then a valid one-word image.
        send_byte(8'h01); send_byte(8'h08);
        status("t3a");
        send_byte(8'h01); send_byte(8'h00);
        send_word($urandom);
        status("t3b");

        // Framing error inside a word; the byte is resent.
        d = $urandom;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(d[7:0]); send_byte(d[15:8]);
        send_bad_stop(d[23:16]);
        send_byte(d[23:16]); send_byte(d[31:24]);
        status("t4");

        // Reset mid-word, then a fresh image.
        d = $urandom;
        send_byte(8'h01); send_byte(8'h00);
        send_byte(d[7:0]); send_byte(d[15:8]);
        @(negedge w_clk) w_rst = 1'b1;
        model_reset();
        repeat (3) @(negedge w_clk);
        chk("t6_waddr", 32'(imem.w_waddr), 0);
        chk("t6_wdata", imem.w_wdata, 0);
        chk("t6_busy",  32'(w_busy), 0);
        chk("t6_done",  32'(w_done), 0);
        chk("t6_err",   32'(w_err), 0);
        w_rst = 1'b0;
        repeat (2) @(negedge w_clk);
        send_byte(8'h01); send_byte(8'h00);
        send_word($urandom);
        status("t6");

        // Maximum 16-bit count is rejected.
        send_byte(8'hFF); send_byte(8'hFF);
        status("big");
        send_byte(8'h00); send_byte(8'h00);
        status("big_clear");

        // Random images.
        for (int f = 0; f < 5; f++) begin
            n = $urandom_range(1, 5);
            send_byte(n[7:0]); send_byte(n[15:8]);
            for (int w = 0; w < int'(n); w++) send_word($urandom);
            status("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
